seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Time-multiplexed driver for a bank of common-cathode seven-segment digits. It holds a `DIGITS`-nibble hex value, decodes one digit per time slot and drives a shared segment bus plus a one-hot digit-select bus. A guard interval at the start of each slot prevents ghosting. New values are double-buffered and take effect only at frame boundaries, so a display frame never mixes old and new values. It sits between the system's status/debug registers and the board's display pins.

## Interface
Parameters:
- `DIGITS`, 4: number of digits, 1..8.
- `DWELL`, 1024: clock cycles per digit slot, ≥ 2.
- `GUARD`, 16: cycles at the start of each slot with all digits disabled, 0..DWELL-1.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: value-write strobe, sampled every cycle.
- `value` in 4*DIGITS: nibble i is the hex value of digit i; digit 0 is least significant and rightmost.
- `blank` in DIGITS: bit i set forces digit i dark; captured together with `value`.
- `segments` out 7: bit i drives segment i (0 top, 1 upper-left, 2 upper-right, 3 middle, 4 lower-left, 5 lower-right, 6 bottom); 1 = lit.
- `digit_enable` out DIGITS: one-hot or zero; 1 = digit powered.
- `frame_start` out 1: one-cycle pulse when the slot of digit 0 begins.
- `load_pending` out 1: high while a loaded value waits for the next frame boundary.

## Operation
- **Decode map (segments, hex):**
  - 0→77, 1→24, 2→5D, 3→6D, 4→2E, 5→6B, 6→7B, 7→25
  - 8→7F, 9→6F, A→3F, b→7A, C→53, d→7C, E→5B, F→1B
- **Registers:**
  - Slot counter `cnt`, range 0..DWELL-1.
  - Digit index `idx`, range 0..DIGITS-1.
  - `pending` value/blank pair with valid flag `pv`.
  - `active` value/blank pair.
- **Counting:**
  - `cnt` increments every cycle.
  - At `cnt == DWELL-1`: `cnt` returns to 0 and `idx` advances.
  - `idx` wraps from DIGITS-1 to 0.
  - A **boundary** is the cycle in which `idx` wraps to 0.
- **Load:**
  - When `load` is high, `pending` captures `value`/`blank` and `pv` is set.
  - A later load before the boundary overwrites the earlier one; last write wins.
- **Boundary:**
  - If `pv` is set, `active` takes `pending` and `pv` clears.
  - If `load` is high in the boundary cycle, `active` takes the incoming `value`/`blank` directly and `pv` clears.
- **Lit condition:** digit `idx` is lit when `cnt >= GUARD` and `active.blank[idx]` is 0.
- **Dark slots:** when the digit is not lit, `digit_enable` = 0 and `segments` = 0.
- **DIGITS == 1:** every slot is a boundary.
- **Reset:**
  - Clears `cnt`, `idx`, `pv`, and both `active` and `pending` (value 0, blank 0).
  - Reset mid-frame discards any pending load.

## Timing
- **Reset values:** `segments`=0, `digit_enable`=0, `frame_start`=0, `load_pending`=0.
- **Latency:**
  - `segments`, `digit_enable` and `frame_start` are registered: they reflect the state of `cnt`/`idx`/`active` with one cycle of latency.
  - `load_pending` is registered and equals `pv`.
- **After reset release** (first cycle has `cnt`=0, `idx`=0):
  - `frame_start` pulses in cycle 1.
  - `digit_enable[0]` first rises in cycle GUARD+1.
- **Frame period:** DIGITS×DWELL cycles; `frame_start` pulses once per frame.
- **Load timing:**
  - A load visible on the display no later than one frame plus one cycle after the strobe.
  - A load in the cycle before a boundary is displayed starting in that frame.
- **Timing path:** decode is combinational from `active`/`idx` into the output registers; no multi-cycle paths.

## Configuration
- Macro `SEVEN_SEGMENT_ZERO_SUPPRESS_EN`.
- **Defined:** leading-zero suppression.
  - Digit i > 0 is dark when nibbles i..DIGITS-1 of `active` are all zero.
  - Digit 0 is never suppressed.
  - Suppression ORs with `blank`.
  - It is computed from `active`, so it changes only at boundaries.
- **Undefined:** all non-blanked digits are shown, including leading zeros; no suppression logic is present.

## Test plan
All scenarios use DIGITS=4, DWELL=8, GUARD=2.

- **Reset:** reset held 3 cycles → all outputs 0; after release, `frame_start` in cycle 1, `digit_enable`=0001 with `segments`=77 in cycles 3..8.
- **Scan order:** load `value`=0x4A1F, `blank`=0 → next frame shows digit0 1B, digit1 24, digit2 3F, digit3 2E. Each digit is enabled 6 cycles and followed by 2 dark cycles; the frame period is 32.
- **Double-buffering:** load 0x1111 mid-frame, then 0x2222 two cycles later → current frame unchanged; `load_pending`=1 until the boundary; next frame shows all 5D.
- **Simultaneous load and boundary:** load 0x0009 in the boundary cycle → that frame shows digit0 6F; `load_pending` stays 0.
- **Blank and suppression:** `blank`=0010 with `value`=0x0030 → digit1 dark.
  - With the macro undefined: digit3 and digit2 show 77.
  - With the macro defined: digit3 and digit2 are dark; digit0 shows 77.
- **Reset mid-operation:** reset during a slot with a pending load → outputs 0 on the next cycle; the pending value is never displayed; display restarts at digit0 with value 0.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-cathode seven-segment scanner with frame-synchronous double-buffered value load.
// Optional leading-zero suppression when SEVEN_SEGMENT_ZERO_SUPPRESS_EN is defined.
module seven_segment_scanner #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1024,
  parameter int GUARD  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_enable,
  output logic                  frame_start,
  output logic                  load_pending
);

  localparam int CW = $clog2(DWELL);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                pv_q, pv_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                fs_q, fs_d;

  logic                slot_end, boundary, lit;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   blank_eff;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h77;  4'h1: decode = 7'h24;
      4'h2: decode = 7'h5D;  4'h3: decode = 7'h6D;
      4'h4: decode = 7'h2E;  4'h5: decode = 7'h6B;
      4'h6: decode = 7'h7B;  4'h7: decode = 7'h25;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h3F;  4'hB: decode = 7'h7A;
      4'hC: decode = 7'h53;  4'hD: decode = 7'h7C;
      4'hE: decode = 7'h5B;  default: decode = 7'h1B;
    endcase
  endfunction

`ifdef SEVEN_SEGMENT_ZERO_SUPPRESS_EN
  // Digit i is suppressed when it and every more-significant nibble are zero.
  logic [DIGITS-1:0] zero_sup;
  assign zero_sup[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_zs
    assign zero_sup[gi] = (act_val_q[4*DIGITS-1:4*gi] == '0);
  end
  assign blank_eff = act_blank_q | zero_sup;
`else
  assign blank_eff = act_blank_q;
`endif

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    boundary = slot_end && (idx_q == IDX_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pv_d         = pv_q;
    act_val_d    = act_val_q;
    act_blank_d  = act_blank_q;
    if (load) begin
      pend_val_d   = value;
      pend_blank_d = blank;
      pv_d         = 1'b1;
    end
    // A load in the boundary cycle bypasses the pending buffer.
    if (boundary) begin
      if (load) begin
        act_val_d   = value;
        act_blank_d = blank;
      end else if (pv_q) begin
        act_val_d   = pend_val_q;
        act_blank_d = pend_blank_q;
      end
      pv_d = 1'b0;
    end
  end

  always_comb begin
    nibble = act_val_q[{idx_q, 2'b00} +: 4];
    lit    = (cnt_q >= GUARD_C) && !blank_eff[idx_q];
    seg_d  = lit ? decode(nibble) : 7'h00;
    en_d   = lit ? (DIGITS'(1) << idx_q) : '0;
    fs_d   = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_blank_q <= '0;
      pv_q         <= 1'b0;
      act_val_q    <= '0;
      act_blank_q  <= '0;
      seg_q        <= '0;
      en_q         <= '0;
      fs_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pv_q         <= pv_d;
      act_val_q    <= act_val_d;
      act_blank_q  <= act_blank_d;
      seg_q        <= seg_d;
      en_q         <= en_d;
      fs_q         <= fs_d;
    end
  end

  assign segments     = seg_q;
  assign digit_enable = en_q;
  assign frame_start  = fs_q;
  assign load_pending = pv_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (DIGITS=4, DWELL=8, GUARD=2).
// Expectations are tagged with the cycle they apply to; a monitor compares at each falling edge.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank = '0;
  logic [6:0]  segments;
  logic [3:0]  digit_enable;
  logic        frame_start;
  logic        load_pending;

  seven_segment_scanner #(.DIGITS(4), .DWELL(8), .GUARD(2)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank(blank),
    .segments(segments), .digit_enable(digit_enable),
    .frame_start(frame_start), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [6:0] seg;
    logic [3:0] en;
    logic       fs;
    logic       lp;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;
  localparam int B = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_abs(input int c, input logic [6:0] s, input logic [3:0] e,
                          input logic f, input logic l);
    exp_t x;
    x.c = c; x.seg = s; x.en = e; x.fs = f; x.lp = l;
    exp_q.push_back(x);
  endtask

  task automatic push(input int k, input logic [6:0] s, input logic [3:0] e,
                      input logic f, input logic l);
    push_abs(B + k, s, e, f, l);
  endtask

  task automatic wait_k(input int k);
    while (cyc < B + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int k, input logic [15:0] v, input logic [3:0] b);
    wait_k(k);
    load = 1'b1; value = v; blank = b;
    wait_k(k + 1);
    load = 1'b0;
  endtask

  // Monitor: compares whenever the head expectation's cycle is reached.
  always @(negedge clk) begin
    if (!done) begin
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL missed_check cyc=%0d required at cyc=%0d", cyc, exp_q[0].c);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        exp_t x;
        x = exp_q.pop_front();
        checks++;
        if (segments !== x.seg || digit_enable !== x.en ||
            frame_start !== x.fs || load_pending !== x.lp) begin
          errors++;
          $display("FAIL cycle_k=%0d got seg=%h en=%b fs=%b lp=%b required seg=%h en=%b fs=%b lp=%b",
                   x.c - B, segments, digit_enable, frame_start, load_pending,
                   x.seg, x.en, x.fs, x.lp);
        end else begin
          $display("check k=%0d seg=%h en=%b fs=%b lp=%b ok", x.c - B,
                   segments, digit_enable, frame_start, load_pending);
        end
      end
    end
  end

  initial begin
    // Reset held 3 cycles
    push_abs(2, 7'h00, 4'b0000, 1'b0, 1'b0);
    push_abs(3, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(1,  7'h00, 4'b0000, 1'b1, 1'b0);
    push(2,  7'h00, 4'b0000, 1'b0, 1'b0);
    push(3,  7'h77, 4'b0001, 1'b0, 1'b0);
    push(8,  7'h77, 4'b0001, 1'b0, 1'b0);
    push(9,  7'h00, 4'b0000, 1'b0, 1'b0);
    push(11, 7'h77, 4'b0010, 1'b0, 1'b0);
    wait_k(0);
    reset = 1'b0;

    // Scan order with 0x4A1F
    wait_k(20);
    push(21, 7'h77, 4'b0100, 1'b0, 1'b1);
    push(27, 7'h77, 4'b1000, 1'b0, 1'b1);
    push(31, 7'h77, 4'b1000, 1'b0, 1'b1);
    push(32, 7'h77, 4'b1000, 1'b0, 1'b0);
    push(33, 7'h00, 4'b0000, 1'b1, 1'b0);
    push(35, 7'h1B, 4'b0001, 1'b0, 1'b0);
    push(40, 7'h1B, 4'b0001, 1'b0, 1'b0);
    push(41, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(42, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(43, 7'h24, 4'b0010, 1'b0, 1'b0);
    push(51, 7'h3F, 4'b0100, 1'b0, 1'b0);
    push(64, 7'h2E, 4'b1000, 1'b0, 1'b0);
    push(65, 7'h00, 4'b0000, 1'b1, 1'b0);
    do_load(20, 16'h4A1F, 4'b0000);

    // Double buffering: 0x1111 then 0x2222, last write wins
    wait_k(70);
    push(71,  7'h1B, 4'b0001, 1'b0, 1'b1);
    push(75,  7'h24, 4'b0010, 1'b0, 1'b1);
    push(95,  7'h2E, 4'b1000, 1'b0, 1'b1);
    push(96,  7'h2E, 4'b1000, 1'b0, 1'b0);
    push(97,  7'h00, 4'b0000, 1'b1, 1'b0);
    push(99,  7'h5D, 4'b0001, 1'b0, 1'b0);
    push(123, 7'h5D, 4'b1000, 1'b0, 1'b0);
    do_load(70, 16'h1111, 4'b0000);
    do_load(72, 16'h2222, 4'b0000);

    // Load in the boundary cycle
    wait_k(127);
    push(127, 7'h5D, 4'b1000, 1'b0, 1'b0);
    push(128, 7'h5D, 4'b1000, 1'b0, 1'b0);
    push(129, 7'h00, 4'b0000, 1'b1, 1'b0);
    push(131, 7'h6F, 4'b0001, 1'b0, 1'b0);
    push(139, 7'h77, 4'b0010, 1'b0, 1'b0);
    do_load(127, 16'h0009, 4'b0000);

    // Blank and leading-zero suppression
    wait_k(140);
    push(141, 7'h77, 4'b0010, 1'b0, 1'b1);
    push(163, 7'h77, 4'b0001, 1'b0, 1'b0);
    push(171, 7'h00, 4'b0000, 1'b0, 1'b0);
`ifdef SEVEN_SEGMENT_ZERO_SUPPRESS_EN
    push(179, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(187, 7'h00, 4'b0000, 1'b0, 1'b0);
`else
    push(179, 7'h77, 4'b0100, 1'b0, 1'b0);
    push(187, 7'h77, 4'b1000, 1'b0, 1'b0);
`endif
    do_load(140, 16'h0030, 4'b0010);

    // Reset mid-operation discards pending 0x8888
    wait_k(200);
    push(201, 7'h00, 4'b0000, 1'b0, 1'b1);
    push(205, 7'h00, 4'b0000, 1'b0, 1'b1);
    push(206, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(207, 7'h00, 4'b0000, 1'b0, 1'b0);
    push(208, 7'h00, 4'b0000, 1'b1, 1'b0);
    push(210, 7'h77, 4'b0001, 1'b0, 1'b0);
    push(218, 7'h77, 4'b0010, 1'b0, 1'b0);
    push(240, 7'h00, 4'b0000, 1'b1, 1'b0);
    push(242, 7'h77, 4'b0001, 1'b0, 1'b0);
    do_load(200, 16'h8888, 4'b0000);
    wait_k(205);
    reset = 1'b1;
    wait_k(207);
    reset = 1'b0;

    wait_k(250);
    @(negedge clk);
    done = 1;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expectations got %0d remaining required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
